// File: rtl/block_transfer_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block transfer sequencer.
// The sequencer, its interface and the priority encoder all import this package.
package block_transfer_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] PC_INDEX   = 4'd15;
   localparam int         REGLIST_W  = 16;

   // Number of registers named in a transfer list; sizes the block span.
   function automatic logic [4:0] popcount16(input logic [REGLIST_W-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < REGLIST_W; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Command, memory and register-file signals of the block transfer sequencer.
// slave = the sequencer's view, master = the surrounding datapath/controller.
interface block_transfer_sequencer_if
   import block_transfer_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) ();

   logic                 start;
   logic                 load;
   logic                 inc;
   logic                 wb;
   logic [REGLIST_W-1:0] reglist;
   logic [DATA_W-1:0]    base;
   logic [REG_AW-1:0]    base_reg;
   logic                 busy;
   logic                 done;
   logic                 mem_req;
   logic                 mem_we;
   logic [DATA_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 mem_ack;
   logic [DATA_W-1:0]    mem_rdata;
   logic [REG_AW-1:0]    rf_ra;
   logic [DATA_W-1:0]    rf_rd;
   logic                 rf_we;
   logic [REG_AW-1:0]    rf_wa;
   logic [DATA_W-1:0]    rf_wd;
   logic                 pc_we;
   logic [DATA_W-1:0]    pc_wd;

   modport slave (
      input  start, load, inc, wb, reglist, base, base_reg,
      input  mem_ack, mem_rdata, rf_rd,
      output busy, done, mem_req, mem_we, mem_addr, mem_wdata,
      output rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
   );

   modport master (
      output start, load, inc, wb, reglist, base, base_reg,
      output mem_ack, mem_rdata, rf_rd,
      input  busy, done, mem_req, mem_we, mem_addr, mem_wdata,
      input  rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
   );

endinterface

// File: rtl/block_transfer_sequencer_priority_encoder_16.sv
// Lowest-set-bit encoder: picks the next register of a transfer list.
// Purely combinational; valid is low when no bit is set.
module priority_encoder_16 (
   input  logic [15:0] req,
   output logic [3:0]  idx,
   output logic        valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = 15; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM block transfer sequencer: one memory beat per listed register,
// lowest register first, with optional base writeback in the closing cycle.
module block_transfer_sequencer
   import block_transfer_sequencer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 4,
   parameter int WORD_BYTES = 4
) (
   input logic                       clk,
   input logic                       reset,
   block_transfer_sequencer_if.slave bus
);

   state_t               state_q;
   state_t               state_d;
   logic [REGLIST_W-1:0] mask_q;
   logic                 load_q;
   logic                 wb_q;
   logic                 base_loaded_q;
   logic [REG_AW-1:0]    base_reg_q;
   logic [DATA_W-1:0]    addr_q;
   logic [DATA_W-1:0]    final_q;

   logic [3:0]           cur;
   logic                 cur_vld;
   logic                 beat;
   logic [REGLIST_W-1:0] mask_next;
   logic [4:0]           n_regs;
   logic [DATA_W-1:0]    span;
   logic [DATA_W-1:0]    step;

   priority_encoder_16 u_prio (
      .req   (mask_q),
      .idx   (cur),
      .valid (cur_vld)
   );

   assign n_regs    = popcount16(bus.reglist);
   assign step      = DATA_W'(WORD_BYTES);
   assign span      = DATA_W'(n_regs) * step;
   assign beat      = (state_q == XFER) && bus.mem_ack && cur_vld;
   assign mask_next = mask_q & ~(REGLIST_W'(1) << cur);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command capture at start, then mask/address advance once per accepted beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q        <= '0;
         load_q        <= 1'b0;
         wb_q          <= 1'b0;
         base_loaded_q <= 1'b0;
         base_reg_q    <= '0;
         addr_q        <= '0;
         final_q       <= '0;
      end else if (state_q == IDLE && bus.start) begin
         mask_q        <= bus.reglist;
         load_q        <= bus.load;
         wb_q          <= bus.wb;
         base_loaded_q <= bus.load && bus.reglist[bus.base_reg];
         base_reg_q    <= bus.base_reg;
         addr_q        <= bus.inc ? bus.base : bus.base - span;
         final_q       <= bus.inc ? bus.base + span : bus.base - span;
      end else if (beat) begin
         mask_q <= mask_next;
         addr_q <= addr_q + step;
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.rf_ra     = '0;
      bus.rf_we     = 1'b0;
      bus.rf_wa     = '0;
      bus.rf_wd     = '0;
      bus.pc_we     = 1'b0;
      bus.pc_wd     = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = (bus.reglist != '0) ? XFER : FINISH;
            end
         end

         XFER: begin
            bus.busy     = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_we   = !load_q;
            bus.mem_addr = addr_q;
            bus.rf_ra    = REG_AW'(cur);
            if (!load_q) begin
               bus.mem_wdata = bus.rf_rd;
            end
            if (beat) begin
               // R15 goes to the PC port; every other register to the file.
               if (load_q && cur == PC_INDEX) begin
                  bus.pc_we = 1'b1;
                  bus.pc_wd = bus.mem_rdata;
               end else if (load_q) begin
                  bus.rf_we = 1'b1;
                  bus.rf_wa = REG_AW'(cur);
                  bus.rf_wd = bus.mem_rdata;
               end
               if (mask_next == '0) begin
                  state_d = FINISH;
               end
            end
         end

         FINISH: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
            state_d  = IDLE;
            // A base register that was itself loaded keeps the loaded value.
            if (wb_q && !base_loaded_q) begin
               bus.rf_we = 1'b1;
               bus.rf_wa = base_reg_q;
               bus.rf_wd = final_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
Multi-cycle sequencer for ARM LDM/STM block transfers between data memory and the 15-entry register file plus PC.
- Walks a 16-bit register list lowest-index first, one register per memory transaction.
- Loads drive the register file write port (or the PC for R15).
- Stores drive a register file read port; a read of R15 already returns PC+8.
- Sits beside the datapath; the controller stalls instruction fetch while `busy` is high.

Parameters:
- DATA_W, 32, data and address width
- REG_AW, 4, register address width
- WORD_BYTES, 4, address stride per transfer

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- start  in  1  one-cycle request; sampled only in IDLE
- load  in  1  1 = LDM (mem->reg), 0 = STM (reg->mem)
- inc  in  1  1 = increment-after, 0 = decrement-before
- wb  in  1  base writeback enable
- reglist  in  16  bit i set = transfer Ri
- base  in  DATA_W  base address
- base_reg  in  REG_AW  base register number
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  word address
- mem_wdata  out  DATA_W  store data (= rf_rd)
- mem_ack  in  1  transaction accepted/completed this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ack=1
- rf_ra  out  REG_AW  register file read address (stores)
- rf_rd  in  DATA_W  register file read data
- rf_we, rf_wa, rf_wd  out  1/REG_AW/DATA_W  register file write port
- pc_we, pc_wd  out  1/DATA_W  PC write, used when R15 is loaded

Behaviour:
- States: IDLE, XFER, FINISH.
- Reset: state IDLE; all outputs 0 immediately; mask, address and count cleared.
- IDLE, start=1 with reglist≠0:
  - latch the mask, load, wb and base_reg.
  - n = popcount(reglist).
  - inc: addr = base; dec: addr = base − 4n.
  - final = base ± 4n.
  - Go to XFER.
- IDLE, start=1 with reglist=0: go to FINISH; no memory access; final = base.
- XFER:
  - busy=1, mem_req=1, mem_we=!load.
  - cur = lowest set bit of the mask; rf_ra = cur.
  - mem_addr, mem_we and mem_wdata are held stable until mem_ack=1.
- XFER, on mem_ack:
  - load with cur≠15: rf_we=1, rf_wa=cur, rf_wd=mem_rdata, combinationally in the same cycle.
  - load with cur=15: pc_we=1, pc_wd=mem_rdata; rf_we stays 0.
  - Clear bit cur; addr += 4.
  - Mask now empty → FINISH.
- XFER, no ack: no rf_we or pc_we; state and address unchanged.
- FINISH:
  - done=1, busy=1, one cycle, then IDLE.
  - base writeback (rf_we=1, rf_wa=base_reg, rf_wd=final) when wb=1 AND NOT (load AND base_reg in reglist); a loaded base wins.
- Latency with mem_ack tied high: start at cycle 0; transfers in cycles 1..n; done in cycle n+1.
- Address arithmetic is modulo 2^DATA_W; wrap-around is permitted.
- start while busy is ignored.
- Reset mid-sequence aborts immediately; no partial writeback.

Decomposition:
- Shared package holds:
  - state enum (IDLE, XFER, FINISH)
  - WORD_BYTES = 4
  - PC_INDEX = 4'd15
  - REGLIST_W = 16
- One sub-module: priority_encoder_16, lowest set bit → 4-bit index plus valid, purely combinational.

Test Plan:
1. LDM inc, reglist=0x0013, base=0x100, wb=1, base_reg=13, ack high:
   - mem_addr 0x100/0x104/0x108, rf_wa 0/1/4 in cycles 1–3.
   - done in cycle 4 with rf_wa=13, rf_wd=0x10C.
2. STM dec, reglist=0x8003, base=0x200, wb=1:
   - mem_addr 0x1F4/0x1F8/0x1FC, rf_ra 0/1/15.
   - mem_wdata equals rf_rd each beat; writeback 0x1F4.
3. LDM, reglist=0x0001, mem_ack delayed 3 cycles:
   - mem_req and mem_addr=base stable throughout the delay.
   - rf_we only in the ack cycle; done one cycle later.
4. LDM, reglist=0x8004, base_reg=2, wb=1:
   - pc_we=1 with pc_wd=mem_rdata on the R15 beat, with rf_we=0 on that beat.
   - no writeback in FINISH.
5. reglist=0, start=1, wb=1:
   - no mem_req; done in cycle 1.
   - writeback value = base.
6. Reset driven low during XFER after one beat:
   - busy, mem_req and rf_we go 0 immediately with no done.
   - after release, a fresh start completes normally.
